// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Desc   : Shares the data memory between the CPU (priority) and a host port,
//          with a bounded-wait slot for the host and a CPU stall counter.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW            = 8,
  parameter int DW            = 16,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt
);

  localparam logic [3:0] c_MAX_WAIT = 4'(HOST_MAX_WAIT);

  logic [3:0]    r_wait_cnt;
  logic          r_ack_q;
  logic [DW-1:0] r_host_rdata;
  logic [15:0]   r_stall_cnt;

  logic w_host_ok;
  logic w_force;
  logic w_grant_host;
  logic w_grant_cpu;
  logic w_cpu_stall;

  // The ack cycle blocks a new host grant, capping the host at one
  // transaction every two cycles.
  always_comb begin
    w_host_ok    = host_req & ~r_ack_q;
    w_force      = w_host_ok & (r_wait_cnt == c_MAX_WAIT);
    w_grant_host = w_host_ok & (~cpu_req | w_force);
    w_grant_cpu  = cpu_req & ~w_grant_host;
    w_cpu_stall  = cpu_req & w_grant_host;
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we & w_grant_cpu;
    if (w_grant_host) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
    end
    // Reset overrides the strobes combinationally so nothing leaks mid-cycle.
    mem_we    = mem_we & reset;
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = w_cpu_stall & reset;
  assign host_ack   = r_ack_q & reset;
  assign host_rdata = r_host_rdata;
  assign stall_cnt  = r_stall_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_cnt   <= 4'd0;
      r_ack_q      <= 1'b0;
      r_host_rdata <= '0;
      r_stall_cnt  <= 16'd0;
    end else begin
      r_ack_q <= w_grant_host;
      if (w_grant_host) begin
        r_host_rdata <= mem_rdata;
      end

      if (!host_req || w_grant_host) begin
        r_wait_cnt <= 4'd0;
      end else if (w_host_ok && (r_wait_cnt != c_MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      if (w_cpu_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-cycle arbiter that shares the 256x16 data memory (combinational read, synchronous write) between the PCPU load/store port and a host port (loader/debug). The CPU has priority. A bounded-wait counter guarantees the host a slot, and the CPU is stalled during that slot. The block sits between the PCPU `d_*` signals and the `dmem`/`d_mem` instance, and also keeps a CPU stall-cycle counter for debug readout.

## Interface
- `AW`, 8: address width.
- `DW`, 16: data width.
- `HOST_MAX_WAIT`, 4: cycles a pending host request may be refused before it is forced through. Legal range 1..15.
- `clock` input 1: sole clock. All state updates on posedge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `cpu_req` input 1: CPU load/store request this cycle.
- `cpu_we` input 1: CPU store when 1, load when 0.
- `cpu_addr` input AW: CPU address.
- `cpu_wdata` input DW: CPU store data.
- `cpu_rdata` output DW: load data. Equals `mem_rdata`, combinational.
- `cpu_stall` output 1: CPU request refused this cycle. CPU holds all request inputs and freezes its pipeline.
- `host_req` input 1: host request. Level; inputs held stable until `host_ack`.
- `host_we` input 1: host write.
- `host_addr` input AW: host address.
- `host_wdata` input DW: host write data.
- `host_rdata` output DW: registered read data, valid while `host_ack`=1.
- `host_ack` output 1: one-cycle completion pulse.
- `mem_addr` output AW: to memory address.
- `mem_we` output 1: to memory write enable.
- `mem_wdata` output DW: to memory data.
- `mem_rdata` input DW: from memory q.
- `stall_cnt` output 16: count of cycles with `cpu_stall`=1. Saturates at 16'hFFFF.

## Operation
- State registers:
  - `wait_cnt` (4 b)
  - `ack_q` (drives `host_ack`)
  - `host_rdata` (DW)
  - `stall_cnt` (16 b)
- Per-cycle grant decision is combinational from inputs and state:
  - `host_ok` = `host_req` & ~`ack_q`.
  - `force` = `host_ok` & (`wait_cnt` == `HOST_MAX_WAIT`).
  - `grant_host` = `host_ok` & (~`cpu_req` | `force`).
  - `grant_cpu` = `cpu_req` & ~`grant_host`.
- Memory mux:
  - `grant_host`: `mem_addr`/`mem_wdata` come from the host; `mem_we` = `host_we`.
  - Otherwise: `mem_addr`/`mem_wdata` come from the CPU; `mem_we` = `cpu_we` & `grant_cpu`.
  - No grant: `mem_we`=0.
- `cpu_stall` = `cpu_req` & `grant_host`.
- Host completion:
  - At the edge ending a `grant_host` cycle, capture `host_rdata` <= `mem_rdata`. Capture happens even for writes; for a write the value is the pre-write data.
  - `ack_q` <= 1 at that edge, so `host_ack` is high for exactly the next cycle.
  - `ack_q` <= 0 on all other edges.
  - In the ack cycle the host is never granted, even if `host_req` is still high. Maximum host throughput is one transaction per 2 cycles.
- `wait_cnt`:
  - Cleared when `grant_host`, or when `host_req`=0.
  - Incremented when `host_ok` & ~`grant_host`, saturating at `HOST_MAX_WAIT`.
  - Held in the ack cycle.
- `stall_cnt` increments on each edge where `cpu_stall`=1. It never wraps.
- While `reset`=0, `mem_we`, `cpu_stall` and `host_ack` are forced to 0, independent of inputs.

## Timing
- Reset values:
  - `wait_cnt`=0, `ack_q`/`host_ack`=0, `host_rdata`=0, `stall_cnt`=0.
  - `cpu_stall`=0, `mem_we`=0.
- CPU latency: 0 cycles. A granted load returns data in the same cycle; a granted store commits at the cycle-ending edge.
- Host latency: grant cycle G, then `host_ack` in G+1. Worst case from `host_req` rise to ack is `HOST_MAX_WAIT`+1 cycles under continuous `cpu_req`.
- Simultaneous `cpu_req`/`host_req` with `wait_cnt`<`HOST_MAX_WAIT`: CPU wins, and `wait_cnt` increments.
- Same-address write collision is impossible: only one requester drives `mem_we` per cycle.
- Host drops `host_req` before ack (protocol violation): `wait_cnt` clears and no ack is issued. If the drop happens after grant, the ack is still issued.
- Reset asserted mid-transaction: any pending ack is lost and the memory write is suppressed that cycle. After release, the host must re-request.
- Reset release is synchronous to the next posedge. The first decision uses cleared state.

## Test plan
- Idle reset: hold `reset`=0 for 2 cycles with `cpu_req`=1, `cpu_we`=1 -> `mem_we`=0, `cpu_stall`=0, `stall_cnt`=0, memory unchanged.
- CPU only: store 16'hBEEF to 8'h10, then load 8'h10 -> `cpu_stall`=0 throughout, `cpu_rdata`=16'hBEEF in the load cycle.
- Host only: `host_req`, `host_we`=1, addr 8'h20, data 16'h1234, held until ack; then read 8'h20 -> each `host_ack` one cycle after its grant, `host_rdata`=16'h1234 on the read ack, with no grant in either ack cycle.
- Contention, `HOST_MAX_WAIT`=4: `cpu_req` held high and `host_req` raised at cycle 0 -> CPU granted cycles 0-3, host granted cycle 4 with `cpu_stall`=1, `host_ack` at cycle 5, `stall_cnt`=1.
- Back-to-back host under CPU load: host re-requests immediately after each ack for 3 transactions -> each host grant forced after 4 refusals, `stall_cnt`=3, CPU data intact.
- Async reset mid-grant: drop `reset` during a host write grant -> `mem_we` falls immediately, no write occurs, `host_ack` stays 0, `wait_cnt`=0 after release.
